// File: rtl/fm_audio_decim_squelch.sv
// fm_audio_decim_squelch: integrate-and-dump decimator, DC blocker, level meter and hysteretic squelch
module fm_audio_decim_squelch #(
  parameter int W        = 12,
  parameter int LOG2R    = 3,
  parameter int DCSH     = 8,
  parameter int LSH      = 4,
  parameter int OPEN_TH  = 200,
  parameter int CLOSE_TH = 100,
  parameter int HOLD     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] in,
  output logic [W-1:0] out,
  output logic         out_valid,
  output logic         sq_open
);
  localparam int HW = $clog2(HOLD + 1);
  localparam logic [W-1:0] OTH = W'(OPEN_TH);
  localparam logic [W-1:0] CTH = W'(CLOSE_TH);
  typedef enum logic [1:0] {CLOSED, OPENING, OPEN, CLOSING} st_t;
  logic [LOG2R-1:0] cnt;
  logic [W+LOG2R-1:0] sum, sum_n;
  logic [W-1:0] x, y, y2, y_n, ny, lvl;
  logic [W-2:0] a;
  logic [W+DCSH:0] dc_acc;
  logic [W:0] dc;
  logic [W+1:0] d;
  logic [W+LSH-1:0] lvl_acc;
  logic s0v, s1v, s2v, side, q, open_n;
  logic [HW-1:0] hcnt, hcnt_n, hn;
  st_t st, st_n;
  assign sum_n = sum + {{LOG2R{in[W-1]}}, in};
  assign dc = dc_acc[W+DCSH:DCSH];
  assign d = {{2{x[W-1]}}, x} - {dc[W], dc};
  // only y saturates; the tracker integrates the unsaturated difference
  assign y_n = (d[W+1:W-1] == 3'b000 || d[W+1:W-1] == 3'b111) ? d[W-1:0]
             : d[W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  assign ny = -y;
  assign a = y[W-1] ? (ny[W-1] ? '1 : ny[W-2:0]) : y[W-2:0];
  assign lvl = lvl_acc[W+LSH-1:LSH];
  assign sq_open = st == OPEN || st == CLOSING;
  always_comb begin
    side = st == CLOSED || st == OPENING;
    q = side ? lvl >= OTH : lvl < CTH;
    hn = (st == CLOSED || st == OPEN) ? HW'(1) : hcnt + HW'(1);
    st_n = st;
    hcnt_n = hcnt;
    if (s2v) begin
      hcnt_n = q ? hn : '0;
      st_n = q ? (hn >= HW'(HOLD) ? (side ? OPEN : CLOSED) : (side ? OPENING : CLOSING))
           : (st == OPENING ? CLOSED : st == CLOSING ? OPEN : st);
    end
    open_n = st_n == OPEN || st_n == CLOSING;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sum <= '0;
      x <= '0;
      y <= '0;
      y2 <= '0;
      dc_acc <= '0;
      lvl_acc <= '0;
      s0v <= 1'b0;
      s1v <= 1'b0;
      s2v <= 1'b0;
      out <= '0;
      out_valid <= 1'b0;
      st <= CLOSED;
      hcnt <= '0;
    end else begin
      s0v <= en && &cnt;
      if (en) begin
        cnt <= cnt + LOG2R'(1);
        sum <= &cnt ? '0 : sum_n;
        if (&cnt) x <= sum_n[W+LOG2R-1:LOG2R];
      end
      s1v <= s0v;
      if (s0v) begin
        y <= y_n;
        dc_acc <= dc_acc + {{(DCSH-1){d[W+1]}}, d};
      end
      s2v <= s1v;
      if (s1v) begin
        lvl_acc <= lvl_acc + {{(LSH+1){1'b0}}, a} - (lvl_acc >> LSH);
        y2 <= y;
      end
      out_valid <= s2v;
      if (s2v) out <= open_n ? y2 : '0;
      st <= st_n;
      hcnt <= hcnt_n;
    end
  end
endmodule

// File: tb/tb_fm_audio_decim_squelch.sv
// tb_fm_audio_decim_squelch: table vectors plus scoreboarded reference model on two parameterisations
module tb_fm_audio_decim_squelch;
  logic clk = 0, rst = 1, en_a = 0, en_b = 0;
  logic [11:0] in_v = 0, out_a, out_b;
  logic ov_a, ov_b, sq_a, sq_b;
  int cyc = 0, checks = 0, failures = 0, lasta = 0;
  typedef struct {int o; int s; int c;} exp_t;
  typedef struct {int base; int step; int gap; int exp_out; int exp_lat;} vec_t;
  exp_t qa[$], qb[$];
  vec_t tbl[8];
  int acc_m[2], cnt_m[2], lacc[2], st_m[2], hc_m[2];
  longint dca[2];
  int oth[2] = '{0, 200};
  int cth[2] = '{0, 100};
  int hold[2] = '{1, 4};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fm_audio_decim_squelch #(.OPEN_TH(0), .CLOSE_TH(0), .HOLD(1)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .in(in_v), .out(out_a), .out_valid(ov_a), .sq_open(sq_a));
  fm_audio_decim_squelch dut_b (
    .clk(clk), .rst(rst), .en(en_b), .in(in_v), .out(out_b), .out_valid(ov_b), .sq_open(sq_b));

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(negedge clk) if (!rst && ov_a) begin
    exp_t e;
    if (lasta != 0) chk("a_spacing", int'(cyc - lasta >= 8), 1);
    lasta = cyc;
    if (qa.size() == 0) chk("a_unexpected_pulse", 1, 0);
    else begin
      e = qa.pop_front();
      chk("a_out", int'($signed(out_a)), e.o);
      chk("a_sq_open", int'(sq_a), e.s);
      chk("a_pulse_cycle", cyc, e.c);
    end
  end

  always @(negedge clk) if (!rst && ov_b) begin
    exp_t e;
    if (qb.size() == 0) chk("b_unexpected_pulse", 1, 0);
    else begin
      e = qb.pop_front();
      chk("b_out", int'($signed(out_b)), e.o);
      chk("b_sq_open", int'(sq_b), e.s);
      chk("b_pulse_cycle", cyc, e.c);
    end
  end

  function automatic void mreset();
    for (int k = 0; k < 2; k++) begin
      acc_m[k] = 0; cnt_m[k] = 0; lacc[k] = 0; st_m[k] = 0; hc_m[k] = 0; dca[k] = 0;
    end
  endfunction

  task automatic model_block(int k, int x, int ec);
    int dc, d, y, a, lvl;
    exp_t e;
    dc = int'(dca[k] >>> 8);
    d = x - dc;
    y = d > 2047 ? 2047 : d < -2048 ? -2048 : d;
    dca[k] += d;
    a = y < 0 ? (y == -2048 ? 2047 : -y) : y;
    lacc[k] = lacc[k] + a - (lacc[k] >> 4);
    lvl = lacc[k] >> 4;
    case (st_m[k])
      0: if (lvl >= oth[k]) begin hc_m[k] = 1; st_m[k] = hold[k] == 1 ? 2 : 1; end
      1: if (lvl >= oth[k]) begin hc_m[k]++; if (hc_m[k] == hold[k]) st_m[k] = 2; end else st_m[k] = 0;
      2: if (lvl < cth[k]) begin hc_m[k] = 1; st_m[k] = hold[k] == 1 ? 0 : 3; end
      default: if (lvl < cth[k]) begin hc_m[k]++; if (hc_m[k] == hold[k]) st_m[k] = 0; end else st_m[k] = 2;
    endcase
    e.s = (st_m[k] >= 2) ? 1 : 0;
    e.o = e.s ? y : 0;
    e.c = ec;
    if (k == 0) qa.push_back(e); else qb.push_back(e);
  endtask

  task automatic put(int k, bit e, int v);
    @(negedge clk);
    en_a = (k == 0) && e;
    en_b = (k == 1) && e;
    in_v = 12'(v);
  endtask

  task automatic feed(int k, int v);
    put(k, 1, v);
    if (cnt_m[k] == 7) begin
      model_block(k, (acc_m[k] + v) >>> 3, cyc + 4);
      acc_m[k] = 0;
      cnt_m[k] = 0;
    end else begin
      acc_m[k] += v;
      cnt_m[k]++;
    end
  endtask

  task automatic idle(int n, int v);
    repeat (n) put(0, 0, v);
  endtask

  task automatic drain();
    int t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 20) begin
      idle(1, 0);
      t++;
    end
    chk("drain_timeout", qa.size() + qb.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; en_a = 0; en_b = 0;
    @(negedge clk);
    rst = 0;
    qa.delete();
    qb.delete();
    mreset();
  endtask

  task automatic reset_checks(string tag);
    chk({tag, "_out_a"}, int'(out_a), 0);
    chk({tag, "_ov_a"}, int'(ov_a), 0);
    chk({tag, "_sq_a"}, int'(sq_a), 0);
    chk({tag, "_out_b"}, int'(out_b), 0);
    chk({tag, "_ov_b"}, int'(ov_b), 0);
    chk({tag, "_sq_b"}, int'(sq_b), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    exp_t e;
    tbl = '{'{0, 1, 0, 3, 10}, '{0, 1, 5, 3, 15}, '{1000, 0, 0, 1000, 10}, '{-100, 0, 0, -100, 10},
            '{2047, 0, 0, 2047, 10}, '{-2048, 0, 0, -2048, 10}, '{-3, 1, 0, 0, 10}, '{-8, 1, 0, -5, 10}};
    do_reset();
    reset_checks("reset");
    // fresh-block vectors on the always-open instance: out equals the floored block mean
    foreach (tbl[r]) begin
      do_reset();
      t0 = 0;
      for (int i = 0; i < 8; i++) begin
        if (i == 4) idle(tbl[r].gap, 555);
        put(0, 1, tbl[r].base + tbl[r].step * i);
        if (i == 0) t0 = cyc + 1;
      end
      e.o = tbl[r].exp_out; e.s = 1; e.c = t0 + tbl[r].exp_lat;
      qa.push_back(e);
      drain();
    end
    // constant input decays through the DC tracker
    do_reset();
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) feed(0, 1000);
      drain();
      chk("t2_seq", int'($signed(out_a)), b == 0 ? 1000 : b == 1 ? 997 : 993);
    end
    for (int n = 0; n < 1297 * 8; n++) begin
      feed(0, 1000);
      if ($urandom_range(0, 15) == 0) idle(1, 1234);
    end
    drain();
    chk("t2_settled", int'($signed(out_a) < 10 && $signed(out_a) > -10), 1);
    // square wave opens the default squelch, silence closes it
    do_reset();
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < 8; i++) feed(1, 1600);
      for (int i = 0; i < 8; i++) feed(1, -1600);
    end
    drain();
    chk("t4_open", int'(sq_b), 1);
    for (int n = 0; n < 640; n++) feed(1, 0);
    drain();
    chk("t5_closed", int'(sq_b), 0);
    chk("t5_out_zero", int'(out_b), 0);
    // full-scale step: negative output saturates, then reset while open
    do_reset();
    for (int n = 0; n < 4000; n++) feed(1, 2047);
    for (int n = 0; n < 8; n++) feed(1, -2048);
    drain();
    chk("t6_sat", int'($signed(out_b)), -2048);
    chk("t6_open_before_rst", int'(sq_b), 1);
    do_reset();
    reset_checks("t6_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
